alu_regfile_core: RTL and testbench



---
 rtl/alu_regfile_core.sv | 247 ++++++++++++++++++++++++
 tb/tb_alu_regfile_core.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_regfile_core.sv
// alu_regfile_core
//
// Datapath core: an 8 x 12-bit register file beside a purely combinational
// 12-bit ALU. The ALU does integer and 12-bit floating-point operations.
// The two halves are not wired together inside this module. An external
// controller routes register reads into the instruction operands. It also
// routes the ALU result back into the write data.
//
// Ports
//   clk          sole clock; register writes happen on its rising edge
//   rst          synchronous active-high clear of all eight registers
//   readAddr1    read port 1 address (asynchronous read)
//   readAddr2    read port 2 address (asynchronous read)
//   writeAddr    write port address
//   dataIn       write data
//   writeEn      write enable, sampled at the rising edge
//   instruction  [26:24] opcode, [23:12] operand A, [11:0] operand B
//   readOut1     contents of register readAddr1
//   readOut2     contents of register readAddr2
//   ALU_output   combinational ALU result
//
// Float format: [11] sign, [10:7] exponent (bias 7), [6:0] fraction with a
// hidden leading one. Exponent 0 is zero. There are no Inf/NaN encodings.
// Results are truncated toward zero. Overflow saturates to the largest
// magnitude, and underflow returns +0.

module alu_regfile_core (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  readAddr1,
    input  logic [2:0]  readAddr2,
    input  logic [2:0]  writeAddr,
    input  logic [11:0] dataIn,
    input  logic        writeEn,
    input  logic [26:0] instruction,
    output logic [11:0] readOut1,
    output logic [11:0] readOut2,
    output logic [11:0] ALU_output
);

    typedef enum logic [2:0] {
        OP_ZERO = 3'b000,
        OP_ADD  = 3'b001,
        OP_SUB  = 3'b010,
        OP_MUL  = 3'b011,
        OP_DIV  = 3'b100,
        OP_FADD = 3'b101,
        OP_FMUL = 3'b110,
        OP_MOD  = 3'b111
    } alu_op_t;

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [11:0] regs [8];

    // Reset takes priority over a write on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 12'h000;
            end
        end else if (writeEn) begin
            regs[writeAddr] <= dataIn;
        end
    end

    // Reads come straight from the array with no write bypass.
    // A read of the register being written shows the old value until the edge.
    assign readOut1 = regs[readAddr1];
    assign readOut2 = regs[readAddr2];

    // ------------------------------------------------------------------
    // Instruction decode
    // ------------------------------------------------------------------
    alu_op_t     op;
    logic [11:0] opnd_a;
    logic [11:0] opnd_b;

    assign op     = alu_op_t'(instruction[26:24]);
    assign opnd_a = instruction[23:12];
    assign opnd_b = instruction[11:0];

    // ------------------------------------------------------------------
    // Integer unit (unsigned, modulo 4096)
    // ------------------------------------------------------------------
    logic [11:0] int_add;
    logic [11:0] int_sub;
    logic [11:0] int_mul;
    logic [11:0] int_div;
    logic [11:0] int_mod;

    assign int_add = opnd_a + opnd_b;
    assign int_sub = opnd_a - opnd_b;
    assign int_mul = opnd_a * opnd_b;
    assign int_div = (opnd_b == 12'h000) ? 12'hFFF : opnd_a / opnd_b;
    assign int_mod = (opnd_b == 12'h000) ? opnd_a : opnd_a % opnd_b;

    // ------------------------------------------------------------------
    // Float operand unpack
    // ------------------------------------------------------------------
    // A zero exponent forces the mantissa to zero, so subnormals flush
    // to zero and a zero operand needs no special case in the adder.
    logic       sign_a;
    logic       sign_b;
    logic [3:0] exp_a;
    logic [3:0] exp_b;
    logic [7:0] mant_a;
    logic [7:0] mant_b;

    assign sign_a = opnd_a[11];
    assign sign_b = opnd_b[11];
    assign exp_a  = opnd_a[10:7];
    assign exp_b  = opnd_b[10:7];
    assign mant_a = (exp_a == 4'd0) ? 8'd0 : {1'b1, opnd_a[6:0]};
    assign mant_b = (exp_b == 4'd0) ? 8'd0 : {1'b1, opnd_b[6:0]};

    // ------------------------------------------------------------------
    // Float add
    // ------------------------------------------------------------------
    logic               a_is_bigger;
    logic               big_sign;
    logic [3:0]         big_exp;
    logic [3:0]         small_exp;
    logic [7:0]         big_mant;
    logic [7:0]         small_mant;

    // Put the larger magnitude on the "big" side.
    // {exponent, mantissa} orders magnitudes correctly because zeros carry
    // exponent 0 and mantissa 0. On a tie, operand A is taken as the
    // larger one; a tie only matters for subtraction, and it gives zero.
    always_comb begin
        a_is_bigger = ({exp_a, mant_a} >= {exp_b, mant_b});
        if (a_is_bigger) begin
            big_sign   = sign_a;
            big_exp    = exp_a;
            big_mant   = mant_a;
            small_exp  = exp_b;
            small_mant = mant_b;
        end else begin
            big_sign   = sign_b;
            big_exp    = exp_b;
            big_mant   = mant_b;
            small_exp  = exp_a;
            small_mant = mant_a;
        end
    end

    logic [3:0]         exp_diff;
    logic [23:0]        fadd_sum;
    logic [4:0]         lead_pos;
    logic signed [6:0]  fadd_exp;
    logic [6:0]         fadd_frac;
    logic [11:0]        fadd_result;

    // Align by shifting the larger operand left instead of shifting the
    // smaller one right. No bits are lost this way, so the sum is exact.
    // Truncating once during normalisation then rounds the true result
    // toward zero. This matters for subtraction: discarding the smaller
    // operand's low bits first would round the wrong way.
    // The sum's scale is the smaller exponent, with 14 fraction bits in all.
    always_comb begin
        exp_diff = big_exp - small_exp;
        if (sign_a ^ sign_b) begin
            fadd_sum = ({16'd0, big_mant} << exp_diff) - {16'd0, small_mant};
        end else begin
            fadd_sum = ({16'd0, big_mant} << exp_diff) + {16'd0, small_mant};
        end

        lead_pos = 5'd0;
        for (int i = 0; i < 24; i++) begin
            if (fadd_sum[i]) begin
                lead_pos = 5'(i);
            end
        end

        // Put the leading one at bit 7 and keep the 7 bits below it.
        if (lead_pos >= 5'd7) begin
            fadd_frac = 7'(fadd_sum >> (lead_pos - 5'd7));
        end else begin
            fadd_frac = 7'(fadd_sum << (5'd7 - lead_pos));
        end

        fadd_exp = $signed({2'b00, lead_pos}) + $signed({3'b000, small_exp}) - 7'sd7;

        if (fadd_sum == 24'd0) begin
            fadd_result = 12'h000;
        end else if (fadd_exp > 7'sd15) begin
            fadd_result = {big_sign, 4'hF, 7'h7F};
        end else if (fadd_exp < 7'sd1) begin
            fadd_result = 12'h000;
        end else begin
            fadd_result = {big_sign, fadd_exp[3:0], fadd_frac};
        end
    end

    // ------------------------------------------------------------------
    // Float multiply
    // ------------------------------------------------------------------
    logic [15:0]        fmul_prod;
    logic signed [6:0]  fmul_exp;
    logic [6:0]         fmul_frac;
    logic [11:0]        fmul_result;

    // The product of two 1.7 mantissas lies in [1,4).
    // Bit 15 of the product says whether one extra normalising shift is
    // needed. Both biases add in, so one bias is taken back out.
    always_comb begin
        fmul_prod = {8'd0, mant_a} * {8'd0, mant_b};
        if (fmul_prod[15]) begin
            fmul_frac = 7'(fmul_prod >> 8);
            fmul_exp  = $signed({3'b000, exp_a}) + $signed({3'b000, exp_b}) - 7'sd6;
        end else begin
            fmul_frac = 7'(fmul_prod >> 7);
            fmul_exp  = $signed({3'b000, exp_a}) + $signed({3'b000, exp_b}) - 7'sd7;
        end

        if ((exp_a == 4'd0) || (exp_b == 4'd0)) begin
            fmul_result = 12'h000;
        end else if (fmul_exp > 7'sd15) begin
            fmul_result = {sign_a ^ sign_b, 4'hF, 7'h7F};
        end else if (fmul_exp < 7'sd1) begin
            fmul_result = 12'h000;
        end else begin
            fmul_result = {sign_a ^ sign_b, fmul_exp[3:0], fmul_frac};
        end
    end

    // ------------------------------------------------------------------
    // Result select
    // ------------------------------------------------------------------
    always_comb begin
        ALU_output = 12'h000;
        case (op)
            OP_ZERO: ALU_output = 12'h000;
            OP_ADD:  ALU_output = int_add;
            OP_SUB:  ALU_output = int_sub;
            OP_MUL:  ALU_output = int_mul;
            OP_DIV:  ALU_output = int_div;
            OP_FADD: ALU_output = fadd_result;
            OP_FMUL: ALU_output = fmul_result;
            OP_MOD:  ALU_output = int_mod;
            default: ALU_output = 12'h000;
        endcase
    end

endmodule

// File: tb/tb_alu_regfile_core.sv
// tb_alu_regfile_core
//
// Self-checking bench for alu_regfile_core.
// It runs directed cases for reset, write, read-during-write and the ALU
// boundaries, then randomized ALU instructions and random register-file
// traffic. Expected values come from a behavioural model:
//   - integer ops use plain int arithmetic;
//   - float ops are decoded to real numbers, computed exactly, and
//     re-encoded with truncation toward zero;
//   - the register file is mirrored in an array.

module tb_alu_regfile_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  readAddr1;
    logic [2:0]  readAddr2;
    logic [2:0]  writeAddr;
    logic [11:0] dataIn;
    logic        writeEn;
    logic [26:0] instruction;
    logic [11:0] readOut1;
    logic [11:0] readOut2;
    logic [11:0] ALU_output;

    int checkCount = 0;
    int errorCount = 0;

    logic [11:0] refRegs [8];

    alu_regfile_core dut (
        .clk         (clk),
        .rst         (rst),
        .readAddr1   (readAddr1),
        .readAddr2   (readAddr2),
        .writeAddr   (writeAddr),
        .dataIn      (dataIn),
        .writeEn     (writeEn),
        .instruction (instruction),
        .readOut1    (readOut1),
        .readOut2    (readOut2),
        .ALU_output  (ALU_output)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    // Present an ALU instruction and let the combinational result settle.
    task automatic applyStimulus(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
        instruction = {op, a, b};
        #1;
    endtask

    // Drive one register-file cycle and mirror its effect in the model.
    task automatic writeReg(input logic [2:0] addr, input logic [11:0] data, input logic en, input logic rstVal);
        @(negedge clk);
        writeAddr = addr;
        dataIn    = data;
        writeEn   = en;
        rst       = rstVal;
        @(posedge clk);
        if (rstVal) begin
            for (int i = 0; i < 8; i++) refRegs[i] = 12'h000;
        end else if (en) begin
            refRegs[addr] = data;
        end
        #1;
        writeEn = 1'b0;
        rst     = 1'b0;
    endtask

    function automatic real pow2(input int n);
        real p;
        p = 1.0;
        if (n >= 0) begin
            for (int i = 0; i < n; i++) p = p * 2.0;
        end else begin
            for (int i = 0; i < -n; i++) p = p / 2.0;
        end
        return p;
    endfunction

    function automatic real fpDecode(input logic [11:0] x);
        real mag;
        int  e;
        int  f;
        e = int'(x[10:7]);
        f = int'(x[6:0]);
        if (e == 0) return 0.0;
        mag = (1.0 + real'(f) / 128.0) * pow2(e - 7);
        return x[11] ? -mag : mag;
    endfunction

    function automatic logic [11:0] fpEncode(input real r);
        real  mag;
        int   e;
        int   frac;
        logic s;
        if (r == 0.0) return 12'h000;
        s   = (r < 0.0);
        mag = s ? -r : r;
        if (mag >= 512.0) return {s, 4'hF, 7'h7F};
        if (mag < pow2(-6)) return 12'h000;
        e = 15;
        while (mag < pow2(e - 7)) e--;
        frac = $rtoi((mag / pow2(e - 7) - 1.0) * 128.0);
        return {s, 4'(e), 7'(frac)};
    endfunction

    function automatic logic [11:0] refAlu(input logic [2:0] op, input logic [11:0] a, input logic [11:0] b);
        int ia;
        int ib;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0:    return 12'h000;
            3'd1:    return 12'((ia + ib) % 4096);
            3'd2:    return 12'((ia - ib + 4096) % 4096);
            3'd3:    return 12'((ia * ib) % 4096);
            3'd4:    return (ib == 0) ? 12'hFFF : 12'(ia / ib);
            3'd5:    return fpEncode(fpDecode(a) + fpDecode(b));
            3'd6:    return fpEncode(fpDecode(a) * fpDecode(b));
            default: return (ib == 0) ? a : 12'(ia % ib);
        endcase
    endfunction

    initial begin
        logic [2:0]  op;
        logic [11:0] a;
        logic [11:0] b;
        logic [11:0] saved;

        rst         = 1'b1;
        writeEn     = 1'b0;
        writeAddr   = 3'd0;
        dataIn      = 12'h000;
        readAddr1   = 3'd0;
        readAddr2   = 3'd0;
        instruction = 27'd0;
        for (int i = 0; i < 8; i++) refRegs[i] = 12'h000;

        // Reset, then every address on both ports reads zero.
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            readAddr1 = 3'(i);
            readAddr2 = 3'(7 - i);
            #1;
            checkOutput($sformatf("reset rd1 R%0d", i), readOut1, 12'h000);
            checkOutput($sformatf("reset rd2 R%0d", 7 - i), readOut2, 12'h000);
        end

        // Reset beats a write on the same edge.
        writeReg(3'd3, 12'hABC, 1'b1, 1'b1);
        readAddr1 = 3'd3;
        #1;
        checkOutput("reset overrides write R3", readOut1, 12'h000);

        // Basic writes and a disabled write.
        writeReg(3'd0, 12'd100, 1'b1, 1'b0);
        writeReg(3'd1, 12'd2, 1'b1, 1'b0);
        writeReg(3'd7, 12'h123, 1'b0, 1'b0);
        readAddr1 = 3'd0;
        readAddr2 = 3'd1;
        #1;
        checkOutput("R0 write", readOut1, 12'd100);
        checkOutput("R1 write", readOut2, 12'd2);
        readAddr1 = 3'd7;
        #1;
        checkOutput("R7 no write", readOut1, 12'h000);

        // Integer ops on register contents A = 100, B = 2.
        readAddr1 = 3'd0;
        #1;
        applyStimulus(3'b010, readOut1, readOut2); checkOutput("sub 100-2", ALU_output, 12'd98);
        applyStimulus(3'b011, readOut1, readOut2); checkOutput("mul 100*2", ALU_output, 12'd200);
        applyStimulus(3'b100, readOut1, readOut2); checkOutput("div 100/2", ALU_output, 12'd50);
        applyStimulus(3'b111, readOut1, readOut2); checkOutput("mod 100%2", ALU_output, 12'd0);
        applyStimulus(3'b001, readOut1, readOut2); checkOutput("add 100+2", ALU_output, 12'd102);

        // Round trip: ALU result routed into the write port for R2.
        @(negedge clk);
        dataIn    = ALU_output;
        writeAddr = 3'd2;
        writeEn   = 1'b1;
        @(posedge clk);
        #1;
        writeEn    = 1'b0;
        refRegs[2] = 12'h066;
        readAddr1  = 3'd2;
        #1;
        checkOutput("round trip R2", readOut1, 12'h066);

        // Integer boundaries.
        applyStimulus(3'b001, 12'hFFF, 12'h001); checkOutput("add wrap", ALU_output, 12'h000);
        applyStimulus(3'b010, 12'h000, 12'h001); checkOutput("sub wrap", ALU_output, 12'hFFF);
        applyStimulus(3'b100, 12'h123, 12'h000); checkOutput("div by 0", ALU_output, 12'hFFF);
        applyStimulus(3'b111, 12'h5A5, 12'h000); checkOutput("mod by 0", ALU_output, 12'h5A5);
        applyStimulus(3'b000, 12'hFFF, 12'hFFF); checkOutput("op zero", ALU_output, 12'h000);

        // Float ops with R5 = R6 = 3.0.
        writeReg(3'd5, 12'h440, 1'b1, 1'b0);
        writeReg(3'd6, 12'h440, 1'b1, 1'b0);
        readAddr1 = 3'd5;
        readAddr2 = 3'd6;
        #1;
        applyStimulus(3'b101, readOut1, readOut2); checkOutput("fadd 3+3", ALU_output, 12'h4C0);
        applyStimulus(3'b110, readOut1, readOut2); checkOutput("fmul 3*3", ALU_output, 12'h510);
        saved = ALU_output;
        writeReg(3'd7, saved, 1'b1, 1'b0);
        readAddr1 = 3'd7;
        #1;
        checkOutput("fmul to R7", readOut1, 12'h510);
        applyStimulus(3'b101, 12'h440, 12'hC40); checkOutput("fadd 3-3", ALU_output, 12'h000);
        applyStimulus(3'b110, 12'h7FF, 12'h7FF); checkOutput("fmul max*max", ALU_output, 12'h7FF);
        applyStimulus(3'b101, 12'hFFF, 12'hFFF); checkOutput("fadd -max-max", ALU_output, 12'hFFF);
        applyStimulus(3'b110, 12'h080, 12'h080); checkOutput("fmul underflow", ALU_output, 12'h000);
        applyStimulus(3'b101, 12'h000, 12'hC40); checkOutput("fadd 0+-3", ALU_output, 12'hC40);

        // Read-during-write: old value before the edge, new value after it.
        writeReg(3'd4, 12'h111, 1'b1, 1'b0);
        @(negedge clk);
        readAddr1 = 3'd4;
        writeAddr = 3'd4;
        dataIn    = 12'h222;
        writeEn   = 1'b1;
        #1;
        checkOutput("rdw before edge", readOut1, 12'h111);
        @(posedge clk);
        #1;
        writeEn    = 1'b0;
        refRegs[4] = 12'h222;
        checkOutput("rdw after edge", readOut1, 12'h222);

        // Randomized ALU instructions against the model.
        for (int n = 0; n < 400; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = 12'($urandom);
            b  = ($urandom_range(0, 7) == 0) ? 12'h000 : 12'($urandom);
            applyStimulus(op, a, b);
            checkOutput($sformatf("alu op%0d a=%h b=%h", op, a, b), ALU_output, refAlu(op, a, b));
        end

        // Random register-file traffic with occasional mid-sequence resets.
        for (int n = 0; n < 300; n++) begin
            @(negedge clk);
            readAddr1 = 3'($urandom);
            readAddr2 = 3'($urandom);
            writeAddr = ($urandom_range(0, 3) == 0) ? readAddr1 : 3'($urandom);
            dataIn    = 12'($urandom);
            writeEn   = 1'($urandom);
            rst       = ($urandom_range(0, 15) == 0);
            #1;
            checkOutput($sformatf("rand pre rd1 R%0d", readAddr1), readOut1, refRegs[readAddr1]);
            checkOutput($sformatf("rand pre rd2 R%0d", readAddr2), readOut2, refRegs[readAddr2]);
            @(posedge clk);
            if (rst) begin
                for (int i = 0; i < 8; i++) refRegs[i] = 12'h000;
            end else if (writeEn) begin
                refRegs[writeAddr] = dataIn;
            end
            #1;
            checkOutput($sformatf("rand post rd1 R%0d", readAddr1), readOut1, refRegs[readAddr1]);
        end
        rst     = 1'b0;
        writeEn = 1'b0;

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule
